// File: rtl/oh_padring_ctrl.sv
// Padring side controller: per-pad shadow/active config registers, a register
// bus, and a power-up sequencer that holds pads safe until power-ok has settled.
`timescale 1ns/1ps
module oh_padring_ctrl #(
  parameter int NGPIO  = 8,
  parameter int CFGW   = 8,
  parameter int AW     = 8,
  parameter int SETTLE = 16,
  parameter int CNTW   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  poc_in,
  input  logic                  reg_access,
  input  logic                  reg_write,
  input  logic [AW-1:0]         reg_addr,
  input  logic [31:0]           reg_wdata,
  output logic [31:0]           reg_rdata,
  output logic                  reg_ack,
  output logic [NGPIO*CFGW-1:0] pad_cfg,
  output logic [NGPIO-1:0]      pad_ie,
  output logic [NGPIO-1:0]      pad_oen,
  output logic                  status_ready
);

  localparam int PW = CFGW + 2;
  localparam logic [AW-1:0]   ADDR_CTRL   = AW'('h80);
  localparam logic [AW-1:0]   ADDR_STATUS = AW'('h81);
  localparam logic [CNTW-1:0] SETTLE_LAST = CNTW'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_SAFE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_APPLY  = 2'd2,
    ST_RUN    = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic poc_meta_q, poc_meta_d;
  logic poc_sync_q, poc_sync_d;
  logic force_safe_q, force_safe_d;
  logic commit_pend_q, commit_pend_d;
  logic [NGPIO-1:0][PW-1:0] shadow_q, shadow_d;
  logic [NGPIO-1:0][PW-1:0] active_q, active_d;
  logic [31:0] rdata_q, rdata_d;
  logic ack_q, ack_d;
  logic [NGPIO*CFGW-1:0] pad_cfg_q, pad_cfg_d;
  logic [NGPIO-1:0] pad_ie_q, pad_ie_d;
  logic [NGPIO-1:0] pad_oen_q, pad_oen_d;
  logic ready_q, ready_d;

  logic wr_en, rd_en, ctrl_wr;

  always_comb begin
    poc_meta_d    = poc_in;
    poc_sync_d    = poc_meta_q;
    wr_en         = reg_access && reg_write;
    rd_en         = reg_access && !reg_write;
    ctrl_wr       = wr_en && (reg_addr == ADDR_CTRL);
    ack_d         = reg_access;
    rdata_d       = rdata_q;
    shadow_d      = shadow_q;
    force_safe_d  = force_safe_q;
    commit_pend_d = ctrl_wr && reg_wdata[0] && (state_q == ST_RUN);

    if (ctrl_wr) force_safe_d = reg_wdata[1];
    if (rd_en) begin
      rdata_d = 32'd0;
      if (reg_addr == ADDR_CTRL)   rdata_d = {30'd0, force_safe_q, 1'b0};
      if (reg_addr == ADDR_STATUS) rdata_d = {29'd0, poc_sync_q, state_q};
    end
    for (int i = 0; i < NGPIO; i++) begin
      if (reg_addr == AW'(i)) begin
        if (wr_en) shadow_d[i] = reg_wdata[PW-1:0];
        if (rd_en) rdata_d = 32'(shadow_q[i]);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      ST_SAFE: if (poc_sync_q && !force_safe_q) state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (!poc_sync_q || force_safe_q) state_d = ST_SAFE;
        else if (cnt_q == SETTLE_LAST)   state_d = ST_APPLY;
        else                             cnt_d   = cnt_q + 1'b1;
      end
      ST_APPLY: state_d = ST_RUN;
      ST_RUN:   if (!poc_sync_q || force_safe_q) state_d = ST_SAFE;
      default:  state_d = ST_SAFE;
    endcase

    // A late commit loses to a simultaneous power loss or force_safe.
    active_d = active_q;
    if ((state_q == ST_APPLY) ||
        (commit_pend_q && (state_q == ST_RUN) && (state_d == ST_RUN)))
      active_d = shadow_q;

    pad_cfg_d = '0;
    pad_ie_d  = '0;
    pad_oen_d = '1;
    ready_d   = (state_d == ST_RUN);
    if (state_d == ST_RUN) begin
      for (int i = 0; i < NGPIO; i++) begin
        pad_cfg_d[i*CFGW +: CFGW] = active_d[i][CFGW-1:0];
        pad_ie_d[i]               = active_d[i][CFGW];
        pad_oen_d[i]              = ~active_d[i][CFGW+1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_SAFE;
      cnt_q         <= '0;
      poc_meta_q    <= 1'b0;
      poc_sync_q    <= 1'b0;
      force_safe_q  <= 1'b0;
      commit_pend_q <= 1'b0;
      shadow_q      <= '0;
      active_q      <= '0;
      rdata_q       <= '0;
      ack_q         <= 1'b0;
      pad_cfg_q     <= '0;
      pad_ie_q      <= '0;
      pad_oen_q     <= '1;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      poc_meta_q    <= poc_meta_d;
      poc_sync_q    <= poc_sync_d;
      force_safe_q  <= force_safe_d;
      commit_pend_q <= commit_pend_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      rdata_q       <= rdata_d;
      ack_q         <= ack_d;
      pad_cfg_q     <= pad_cfg_d;
      pad_ie_q      <= pad_ie_d;
      pad_oen_q     <= pad_oen_d;
      ready_q       <= ready_d;
    end
  end

  assign reg_rdata    = rdata_q;
  assign reg_ack      = ack_q;
  assign pad_cfg      = pad_cfg_q;
  assign pad_ie       = pad_ie_q;
  assign pad_oen      = pad_oen_q;
  assign status_ready = ready_q;

endmodule

// File: tb/tb_oh_padring_ctrl.sv
// Directed bench for oh_padring_ctrl: bus reads are scored through a queue by a
// monitor; pad/sequencer timing is checked edge by edge against hand values.
`timescale 1ns/1ps
module tb_oh_padring_ctrl;

  localparam int NGPIO = 8;
  localparam int CFGW  = 8;
  localparam int AW    = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic poc_in = 1'b0;
  logic reg_access = 1'b0;
  logic reg_write = 1'b0;
  logic [AW-1:0] reg_addr = '0;
  logic [31:0] reg_wdata = '0;
  logic [31:0] reg_rdata;
  logic reg_ack;
  logic [NGPIO*CFGW-1:0] pad_cfg;
  logic [NGPIO-1:0] pad_ie;
  logic [NGPIO-1:0] pad_oen;
  logic status_ready;

  typedef struct {
    logic        check_data;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int failures = 0;

  oh_padring_ctrl #(.NGPIO(NGPIO), .CFGW(CFGW), .AW(AW), .SETTLE(4), .CNTW(8)) dut (
    .clk(clk), .reset(reset), .poc_in(poc_in),
    .reg_access(reg_access), .reg_write(reg_write), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_ack(reg_ack),
    .pad_cfg(pad_cfg), .pad_ie(pad_ie), .pad_oen(pad_oen),
    .status_ready(status_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input string name);
    exp_t e;
    e.check_data = !wr;
    e.data       = exp_rd;
    e.name       = name;
    sb.push_back(e);
    reg_access = 1'b1;
    reg_write  = wr;
    reg_addr   = addr;
    reg_wdata  = wdata;
    tick(1);
    reg_access = 1'b0;
    reg_write  = 1'b0;
  endtask

  task automatic check_safe(input string name);
    check({name, " oen"}, 64'(pad_oen), 64'hFF);
    check({name, " ie"}, 64'(pad_ie), 64'h0);
    check({name, " cfg"}, pad_cfg, 64'h0);
    check({name, " ready"}, 64'(status_ready), 64'h0);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (reg_ack) begin
          tests++;
          if (sb.size() == 0) begin
            failures++;
            $display("[TB] FAIL spurious_ack: got ack=1 expected ack=0");
          end else begin
            exp_t e;
            e = sb.pop_front();
            if (e.check_data && (reg_rdata !== e.data)) begin
              failures++;
              $display("[TB] FAIL %s: got rdata 0x%0h expected 0x%0h", e.name, reg_rdata, e.data);
            end
          end
        end
      end
    join_none

    // Reset values
    tick(2);
    check_safe("reset");
    check("reset ack", 64'(reg_ack), 64'h0);
    check("reset rdata", 64'(reg_rdata), 64'h0);
    reset = 1'b0;
    tick(3);

    // Power-up: ready exactly 2+SETTLE+1 edges after poc is sampled
    poc_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check($sformatf("powerup ready e%0d", i), 64'(status_ready), 64'(i == 7));
      check($sformatf("powerup oen e%0d", i), 64'(pad_oen), 64'hFF);
    end
    bus(1'b0, 8'h81, 32'h0, 32'h7, "status_run");

    // Shadow write/readback, then commit lands two cycles after the access
    bus(1'b1, 8'h03, 32'h2A5, 32'h0, "wr_pad3");
    bus(1'b0, 8'h03, 32'h0, 32'h2A5, "rd_pad3");
    check("no_commit oen", 64'(pad_oen), 64'hFF);
    bus(1'b1, 8'h80, 32'h1, 32'h0, "commit");
    check("commit+1 oen", 64'(pad_oen), 64'hFF);
    tick(1);
    check("commit+2 cfg", pad_cfg, 64'h00000000A5000000);
    check("commit+2 oen", 64'(pad_oen), 64'hF7);
    check("commit+2 ie", 64'(pad_ie), 64'h00);

    // Power loss in RUN
    poc_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check($sformatf("poc_drop ready e%0d", i), 64'(status_ready), 64'(i < 2));
    end
    check_safe("poc_drop");
    bus(1'b0, 8'h81, 32'h0, 32'h0, "status_safe");
    poc_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check($sformatf("repower ready e%0d", i), 64'(status_ready), 64'(i == 7));
    end
    check("repower cfg", pad_cfg, 64'h00000000A5000000);
    check("repower oen", 64'(pad_oen), 64'hF7);

    // One-cycle poc glitch during SETTLE restarts the settle count
    poc_in = 1'b0;
    tick(4);
    poc_in = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i == 4) poc_in = 1'b0;
      if (i == 5) poc_in = 1'b1;
      tick(1);
      check($sformatf("glitch ready e%0d", i), 64'(status_ready), 64'(i == 12));
      check($sformatf("glitch oen e%0d", i), 64'(pad_oen), (i == 12) ? 64'hF7 : 64'hFF);
    end

    // force_safe, commit while forced, then release
    bus(1'b1, 8'h80, 32'h2, 32'h0, "force_set");
    check("force+0 ready", 64'(status_ready), 64'h1);
    tick(1);
    check_safe("force+1");
    bus(1'b1, 8'h03, 32'h1C3, 32'h0, "wr_pad3_b");
    bus(1'b1, 8'h80, 32'h3, 32'h0, "commit_forced");
    tick(3);
    check_safe("commit_forced");
    bus(1'b0, 8'h80, 32'h0, 32'h2, "rd_ctrl");
    bus(1'b1, 8'h80, 32'h0, 32'h0, "force_clr");
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check($sformatf("release ready e%0d", i), 64'(status_ready), 64'(i == 5));
    end
    check("release cfg", pad_cfg, 64'h00000000C3000000);
    check("release ie", 64'(pad_ie), 64'h08);
    check("release oen", 64'(pad_oen), 64'hFF);

    // Unmapped addresses read zero but are still acked
    bus(1'b0, 8'h03, 32'h0, 32'h1C3, "rd_pad3_b");
    bus(1'b0, 8'h08, 32'h0, 32'h0, "rd_addr_ngpio");
    bus(1'b0, 8'h03, 32'h0, 32'h1C3, "rd_pad3_c");
    bus(1'b0, 8'h55, 32'h0, 32'h0, "rd_addr_55");

    // Reset in the middle of SETTLE
    poc_in = 1'b0;
    tick(4);
    bus(1'b1, 8'h00, 32'h3FF, 32'h0, "wr_pad0");
    bus(1'b0, 8'h00, 32'h0, 32'h3FF, "rd_pad0");
    poc_in = 1'b1;
    tick(4);
    reset = 1'b1;
    #1;
    check_safe("mid_reset");
    check("mid_reset rdata", 64'(reg_rdata), 64'h0);
    poc_in = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
    bus(1'b0, 8'h00, 32'h0, 32'h0, "rd_pad0_after_reset");
    bus(1'b0, 8'h03, 32'h0, 32'h0, "rd_pad3_after_reset");
    bus(1'b0, 8'h81, 32'h0, 32'h0, "status_after_reset");

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick(1);
    tick(2);
    tests++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL missing_ack: got %0d outstanding expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
